// File: rtl/id_ex_stage_pkg.sv
// Shared ALU function codes and the ID/EX control record.
package id_ex_stage_pkg;

  localparam logic [5:0] ALU_ADD   = 6'b000000;
  localparam logic [5:0] ALU_SUB   = 6'b000001;
  localparam logic [5:0] ALU_AND   = 6'b011000;
  localparam logic [5:0] ALU_OR    = 6'b011110;
  localparam logic [5:0] ALU_XOR   = 6'b010110;
  localparam logic [5:0] ALU_NOR   = 6'b010001;
  localparam logic [5:0] ALU_PASSA = 6'b011010;
  localparam logic [5:0] ALU_SLL   = 6'b100000;
  localparam logic [5:0] ALU_SRL   = 6'b100001;
  localparam logic [5:0] ALU_SRA   = 6'b100011;
  localparam logic [5:0] ALU_EQ    = 6'b110011;
  localparam logic [5:0] ALU_NEQ   = 6'b110001;
  localparam logic [5:0] ALU_LT    = 6'b110101;
  localparam logic [5:0] ALU_LEZ   = 6'b111101;
  localparam logic [5:0] ALU_LTZ   = 6'b111011;
  localparam logic [5:0] ALU_GTZ   = 6'b111111;
  localparam logic [5:0] BUBBLE_FUN = ALU_ADD;

  // Width-independent part of the pipeline register.
  typedef struct packed {
    logic       valid;
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic       alusrc1;
    logic       alusrc2;
    logic       sign;
    logic [5:0] alufun;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [4:0] shamt;
  } ex_ctrl_t;

  // Bubble: rs/rt zeroed so a bubble can never match a forward source.
  function automatic ex_ctrl_t bubble_ctrl();
    ex_ctrl_t c;
    c        = '0;
    c.alufun = BUBBLE_FUN;
    return c;
  endfunction

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// One operand's bypass select: EX/MEM beats MEM/WB beats register data.
module fwd_mux #(
  parameter int DATA_W = 32
) (
  input  logic [4:0]        src,
  input  logic [DATA_W-1:0] reg_data,
  input  logic              exmem_regwrite,
  input  logic [4:0]        exmem_rd,
  input  logic [DATA_W-1:0] exmem_result,
  input  logic              memwb_regwrite,
  input  logic [4:0]        memwb_rd,
  input  logic [DATA_W-1:0] memwb_data,
  output logic [DATA_W-1:0] data
);

  logic hit_exmem, hit_memwb;

  // r0 is hardwired zero, so a write to it is never a valid bypass.
  assign hit_exmem = exmem_regwrite && (exmem_rd != 5'd0) && (exmem_rd == src);
  assign hit_memwb = memwb_regwrite && (memwb_rd != 5'd0) && (memwb_rd == src);

  // Priority select, youngest producer first.
  always_comb begin
    data = reg_data;
    if (hit_exmem)      data = exmem_result;
    else if (hit_memwb) data = memwb_data;
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and load-use detection.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [4:0]        id_rs_addr,
  input  logic [4:0]        id_rt_addr,
  input  logic [4:0]        id_rd_addr,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [4:0]        id_shamt,
  input  logic              id_alusrc1,
  input  logic              id_alusrc2,
  input  logic              id_uses_rt,
  input  logic [5:0]        id_alufun,
  input  logic              id_sign,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              id_memwrite,
  input  logic              stall,
  input  logic              flush,
  input  logic              exmem_regwrite,
  input  logic [4:0]        exmem_rd,
  input  logic [DATA_W-1:0] exmem_result,
  input  logic              memwb_regwrite,
  input  logic [4:0]        memwb_rd,
  input  logic [DATA_W-1:0] memwb_data,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [5:0]        alu_fun,
  output logic              alu_sign,
  output logic              ex_valid,
  output logic              ex_regwrite,
  output logic              ex_memread,
  output logic              ex_memwrite,
  output logic [4:0]        ex_rd,
  output logic [DATA_W-1:0] ex_store_data,
  output logic              load_use
);

  ex_ctrl_t                 ctrl, id_ctrl;
  logic [1:0][DATA_W-1:0]   src_data;   // [0]=rs, [1]=rt
  logic [DATA_W-1:0]        imm;
  logic [1:0][4:0]          src_addr;
  logic [1:0][DATA_W-1:0]   fwd;

  assign id_ctrl = '{valid: id_valid, regwrite: id_regwrite, memread: id_memread,
                     memwrite: id_memwrite, alusrc1: id_alusrc1, alusrc2: id_alusrc2,
                     sign: id_sign, alufun: id_alufun, rs: id_rs_addr, rt: id_rt_addr,
                     rd: id_rd_addr, shamt: id_shamt};

  // A load in EX whose destination the ID instruction reads cannot be bypassed in time.
  assign load_use = ctrl.valid && ctrl.memread && (ctrl.rd != 5'd0) && id_valid &&
                    ((ctrl.rd == id_rs_addr) || (id_uses_rt && (ctrl.rd == id_rt_addr)));

  // Pipeline register: flush > stall (hold) > load-use bubble > capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl     <= bubble_ctrl();
      src_data <= '0;
      imm      <= '0;
    end else if (flush || (!stall && load_use)) begin
      ctrl     <= bubble_ctrl();
      src_data <= '0;
      imm      <= '0;
    end else if (!stall) begin
      ctrl     <= id_ctrl;
      src_data <= {id_rt_data, id_rs_data};
      imm      <= id_imm;
    end
  end

  assign src_addr = {ctrl.rt, ctrl.rs};

  // Forwarding stays live while stalled so a held instruction sees fresh results.
  for (genvar g = 0; g < 2; g++) begin : g_fwd
    fwd_mux #(.DATA_W(DATA_W)) u_fwd (
      .src            (src_addr[g]),
      .reg_data       (src_data[g]),
      .exmem_regwrite (exmem_regwrite),
      .exmem_rd       (exmem_rd),
      .exmem_result   (exmem_result),
      .memwb_regwrite (memwb_regwrite),
      .memwb_rd       (memwb_rd),
      .memwb_data     (memwb_data),
      .data           (fwd[g])
    );
  end

  assign alu_a         = ctrl.alusrc1 ? {{(DATA_W-5){1'b0}}, ctrl.shamt} : fwd[0];
  assign alu_b         = ctrl.alusrc2 ? imm : fwd[1];
  assign ex_store_data = fwd[1];
  assign alu_fun       = ctrl.alufun;
  assign alu_sign      = ctrl.sign;
  assign ex_valid      = ctrl.valid;
  assign ex_regwrite   = ctrl.regwrite;
  assign ex_memread    = ctrl.memread;
  assign ex_memwrite   = ctrl.memwrite;
  assign ex_rd         = ctrl.rd;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage with hand-computed expectations.
module tb_id_ex_stage;
  import id_ex_stage_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [4:0]  id_rs_addr, id_rt_addr, id_rd_addr;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic [4:0]  id_shamt;
  logic        id_alusrc1, id_alusrc2, id_uses_rt;
  logic [5:0]  id_alufun;
  logic        id_sign, id_regwrite, id_memread, id_memwrite;
  logic        stall, flush;
  logic        exmem_regwrite;
  logic [4:0]  exmem_rd;
  logic [31:0] exmem_result;
  logic        memwb_regwrite;
  logic [4:0]  memwb_rd;
  logic [31:0] memwb_data;
  logic [31:0] alu_a, alu_b, ex_store_data;
  logic [5:0]  alu_fun;
  logic        alu_sign, ex_valid, ex_regwrite, ex_memread, ex_memwrite, load_use;
  logic [4:0]  ex_rd;

  int nchecks = 0;
  int nerr    = 0;

  id_ex_stage #(.DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
    .id_rd_addr(id_rd_addr), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .id_imm(id_imm), .id_shamt(id_shamt), .id_alusrc1(id_alusrc1),
    .id_alusrc2(id_alusrc2), .id_uses_rt(id_uses_rt), .id_alufun(id_alufun),
    .id_sign(id_sign), .id_regwrite(id_regwrite), .id_memread(id_memread),
    .id_memwrite(id_memwrite), .stall(stall), .flush(flush),
    .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_fun(alu_fun), .alu_sign(alu_sign),
    .ex_valid(ex_valid), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .ex_memwrite(ex_memwrite), .ex_rd(ex_rd), .ex_store_data(ex_store_data),
    .load_use(load_use)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchecks++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_id();
    id_valid = 0; id_rs_addr = 0; id_rt_addr = 0; id_rd_addr = 0;
    id_rs_data = 0; id_rt_data = 0; id_imm = 0; id_shamt = 0;
    id_alusrc1 = 0; id_alusrc2 = 0; id_uses_rt = 0; id_alufun = ALU_ADD;
    id_sign = 0; id_regwrite = 0; id_memread = 0; id_memwrite = 0;
  endtask

  task automatic clr_fwd();
    exmem_regwrite = 0; exmem_rd = 0; exmem_result = 0;
    memwb_regwrite = 0; memwb_rd = 0; memwb_data = 0;
  endtask

  initial begin
    reset = 0; stall = 0; flush = 0;
    clr_id(); clr_fwd();

    // Reset state
    #3;
    chk("rst_alu_a",    alu_a, 32'h0);
    chk("rst_alu_fun",  32'(alu_fun), 32'h0);
    chk("rst_ex_valid", 32'(ex_valid), 32'h0);
    chk("rst_load_use", 32'(load_use), 32'h0);
    step();
    reset = 1;

    // Plain capture, no forwarding
    id_valid = 1; id_rs_addr = 1; id_rt_addr = 2; id_rd_addr = 3;
    id_rs_data = 32'h8000001F; id_rt_data = 32'hFFFFF000; id_alufun = ALU_ADD;
    id_regwrite = 1; id_uses_rt = 1;
    step();
    chk("cap_alu_a",    alu_a, 32'h8000001F);
    chk("cap_alu_b",    alu_b, 32'hFFFFF000);
    chk("cap_alu_fun",  32'(alu_fun), 32'(ALU_ADD));
    chk("cap_ex_valid", 32'(ex_valid), 32'h1);
    chk("cap_ex_rd",    32'(ex_rd), 32'd3);

    // Double match: EX/MEM wins, then MEM/WB, then r0 is never forwarded
    id_rs_addr = 5; id_rt_addr = 6; id_rd_addr = 7;
    id_rs_data = 32'h0000AAAA; id_rt_data = 32'h0000BBBB; id_alufun = ALU_SUB;
    step();
    exmem_regwrite = 1; exmem_rd = 5; exmem_result = 32'h11;
    memwb_regwrite = 1; memwb_rd = 5; memwb_data = 32'h22;
    #1;
    chk("dm_exmem_a", alu_a, 32'h11);
    chk("dm_b_nofwd", alu_b, 32'h0000BBBB);
    chk("dm_fun",     32'(alu_fun), 32'(ALU_SUB));
    exmem_regwrite = 0;
    #1;
    chk("dm_memwb_a", alu_a, 32'h22);
    exmem_regwrite = 1; exmem_rd = 0; memwb_rd = 0;
    #1;
    chk("dm_r0_a", alu_a, 32'h0000AAAA);
    clr_fwd();

    // Load-use: lw r8 in EX, ID reads r8 via rt
    id_rs_addr = 1; id_rt_addr = 2; id_rd_addr = 8; id_memread = 1; id_regwrite = 1;
    id_alufun = ALU_ADD;
    step();
    id_memread = 0; id_rs_addr = 9; id_rt_addr = 8; id_rd_addr = 10;
    id_uses_rt = 1; id_alufun = ALU_AND; id_rs_data = 32'h99; id_rt_data = 32'h88;
    #1;
    chk("lu_hit", 32'(load_use), 32'h1);
    id_uses_rt = 0;
    #1;
    chk("lu_no_rt", 32'(load_use), 32'h0);
    id_uses_rt = 1;
    #1;
    step();
    chk("lu_bub_valid", 32'(ex_valid), 32'h0);
    chk("lu_bub_rw",    32'(ex_regwrite), 32'h0);
    chk("lu_bub_rd",    32'(ex_rd), 32'h0);
    chk("lu_cleared",   32'(load_use), 32'h0);

    // Stall: register holds, forwarded rs tracks a changing EX/MEM result
    step();
    chk("st_cap_rd",  32'(ex_rd), 32'd10);
    chk("st_cap_fun", 32'(alu_fun), 32'(ALU_AND));
    stall = 1; id_rd_addr = 20; id_alufun = ALU_OR;
    exmem_regwrite = 1; exmem_rd = 9;
    for (int k = 1; k <= 3; k++) begin
      exmem_result = 32'(k);
      step();
      chk("st_alu_a", alu_a, 32'(k));
      chk("st_hold_rd", 32'(ex_rd), 32'd10);
    end

    // stall and flush on the same edge: flush wins
    flush = 1;
    step();
    chk("sf_valid", 32'(ex_valid), 32'h0);
    chk("sf_rd",    32'(ex_rd), 32'h0);
    chk("sf_fun",   32'(alu_fun), 32'(BUBBLE_FUN));
    flush = 0; stall = 0;
    id_rd_addr = 12; id_rs_addr = 3; id_rt_addr = 4; id_rs_data = 32'h1234;
    step();
    chk("pre_rst_rd", 32'(ex_rd), 32'd12);

    // Reset mid-stall clears immediately; capture resumes after release
    stall = 1;
    #2;
    reset = 0;
    #1;
    chk("mr_valid", 32'(ex_valid), 32'h0);
    chk("mr_rd",    32'(ex_rd), 32'h0);
    chk("mr_alu_a", alu_a, 32'h0);
    chk("mr_fun",   32'(alu_fun), 32'h0);
    step();
    reset = 1; stall = 0; id_rd_addr = 13;
    step();
    chk("post_rst_rd",    32'(ex_rd), 32'd13);
    chk("post_rst_valid", 32'(ex_valid), 32'h1);

    // Operand source selects; store data still takes forwarded rt
    clr_fwd();
    id_rs_addr = 3; id_rt_addr = 6; id_rs_data = 32'hDEADBEEF; id_rt_data = 32'h1234;
    id_alusrc1 = 1; id_shamt = 5; id_alusrc2 = 1; id_imm = 32'hFFFF8000;
    id_rd_addr = 14; id_alufun = ALU_SLL; id_sign = 1;
    step();
    exmem_regwrite = 1; exmem_rd = 6; exmem_result = 32'h5555;
    #1;
    chk("src_alu_a", alu_a, 32'h00000005);
    chk("src_alu_b", alu_b, 32'hFFFF8000);
    chk("src_store", ex_store_data, 32'h5555);
    chk("src_sign",  32'(alu_sign), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule
